// File: rtl/reset_pkg.sv
// Shared types and constants for the per-project reset sequencer.
package reset_pkg;

    typedef enum logic [1:0] {
        SEQ_WAIT    = 2'd0,
        SEQ_RELEASE = 2'd1,
        SEQ_DONE    = 2'd2
    } seq_state_t;

    localparam logic RST_ASSERT = 1'b1;

endpackage : reset_pkg

// File: rtl/reset_channel.sv
// One reset channel: asynchronous assertion, synchronised deassertion,
// minimum-width stretch and software reset request handling.
module reset_channel #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 8
) (
    input  logic clk,
    input  logic i_cause_n,
    input  logic i_sw_rst,
    output logic o_local_ok
);

    localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_local_ok;
    logic                   w_sync_high;
    logic                   w_sync_high_next;

    assign w_sync_high      = r_sync[SYNC_STAGES-1];
    assign w_sync_high_next = r_sync[SYNC_STAGES-2];

    // The counter is held loaded while the chain is low, so the stretch
    // always starts counting on the edge after the chain goes high.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_sync_high || i_sw_rst) begin
            w_cnt_next = STRETCH_LOAD;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    // local_ok is registered so its rising edge comes straight off a flop.
    always_ff @(posedge clk or negedge i_cause_n) begin
        if (!i_cause_n) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_local_ok <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_cnt      <= w_cnt_next;
            r_local_ok <= w_sync_high_next && (w_cnt_next == '0);
        end
    end

    assign o_local_ok = r_local_ok;

endmodule : reset_channel

// File: rtl/reset_sequencer.sv
// Per-project reset generator: one reset_channel per project plus a
// sequencer that releases the projects one at a time after power-on.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_PROJECTS   = 13,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 8,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_PROJECTS:1] designs_cs,
    input  logic [NUM_PROJECTS:1] sw_rst,
    output logic [NUM_PROJECTS:1] designs_rst,
    output logic                  seq_done
);

    localparam int WAIT_EDGES = SYNC_STAGES + STRETCH_CYCLES;
    localparam int WAIT_W     = $clog2(WAIT_EDGES + 1);
    localparam int STAG_W     = $clog2(STAGGER_CYCLES + 1);
    localparam int IDX_W      = $clog2(NUM_PROJECTS + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_EDGES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST  = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_PENULT = IDX_W'(NUM_PROJECTS - 1);

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [STAG_W-1:0]     r_stag_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_PROJECTS:1] r_released;
    logic [NUM_PROJECTS:1] w_set_release;
    logic [NUM_PROJECTS:1] w_cause_n;
    logic [NUM_PROJECTS:1] w_local_ok;
    logic                  w_wait_done;
    logic                  w_slot_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= SEQ_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEQ_WAIT: begin
                if (w_wait_done) begin
                    if (NUM_PROJECTS == 1) begin
                        w_state_next = SEQ_DONE;
                    end else begin
                        w_state_next = SEQ_RELEASE;
                    end
                end
            end
            // The last project's release and the move to DONE share one edge.
            SEQ_RELEASE: begin
                if (w_slot_done && (r_idx == IDX_PENULT)) begin
                    w_state_next = SEQ_DONE;
                end
            end
            SEQ_DONE: w_state_next = SEQ_DONE;
            default:  w_state_next = SEQ_WAIT;
        endcase
    end

    always_comb begin
        seq_done    = 1'b0;
        w_wait_done = 1'b0;
        w_slot_done = 1'b0;
        case (r_state)
            SEQ_WAIT:    w_wait_done = (r_wait_cnt == WAIT_LAST);
            SEQ_RELEASE: w_slot_done = (r_stag_cnt == STAG_LAST);
            SEQ_DONE:    seq_done    = 1'b1;
            default:     seq_done    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wait_cnt <= '0;
            r_stag_cnt <= '0;
            r_idx      <= '0;
            r_released <= '0;
        end else begin
            r_released <= r_released | w_set_release;
            case (r_state)
                SEQ_WAIT: begin
                    if (w_wait_done) begin
                        r_idx      <= IDX_W'(1);
                        r_stag_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                SEQ_RELEASE: begin
                    if (w_slot_done) begin
                        r_stag_cnt <= '0;
                        r_idx      <= r_idx + 1'b1;
                    end else begin
                        r_stag_cnt <= r_stag_cnt + 1'b1;
                    end
                end
                default: begin
                    r_stag_cnt <= r_stag_cnt;
                end
            endcase
        end
    end

    // Project 1 is released as the wait phase ends; project k>1 when the
    // slot of project k-1 expires.
    genvar gi;
    generate
        for (gi = 1; gi <= NUM_PROJECTS; gi++) begin : g_chan
            assign w_cause_n[gi] = n_rst & designs_cs[gi];

            if (gi == 1) begin : g_first
                assign w_set_release[gi] = w_wait_done;
            end else begin : g_rest
                assign w_set_release[gi] = w_slot_done && (r_idx == IDX_W'(gi - 1));
            end

            reset_channel #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STRETCH_CYCLES(STRETCH_CYCLES)
            ) u_channel (
                .clk       (clk),
                .i_cause_n (w_cause_n[gi]),
                .i_sw_rst  (sw_rst[gi]),
                .o_local_ok(w_local_ok[gi])
            );

            assign designs_rst[gi] = (w_local_ok[gi] & r_released[gi]) ? ~RST_ASSERT : RST_ASSERT;
        end
    endgenerate

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: per-edge expected reset/done values
// are queued when a scenario is set up and popped after each clock edge.
module tb_reset_sequencer;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [NP:1]   designs_cs;
    logic [NP:1]   sw_rst;
    logic [NP:1]   designs_rst;
    logic          seq_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int        cyc;
        logic [NP:1] rst;
        logic      done;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_PROJECTS  (NP),
        .SYNC_STAGES   (2),
        .STRETCH_CYCLES(8),
        .STAGGER_CYCLES(4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .designs_cs (designs_cs),
        .sw_rst     (sw_rst),
        .designs_rst(designs_rst),
        .seq_done   (seq_done)
    );

    // Power-on model: project k leaves reset after edge 10 + 4*(k-1).
    function automatic logic [NP:1] po_rst(input int c);
        logic [NP:1] r;
        for (int k = 1; k <= NP; k++) begin
            r[k] = (c < 10 + 4 * (k - 1)) ? 1'b1 : 1'b0;
        end
        return r;
    endfunction

    task automatic start_seq(input logic [NP:1] cs);
        n_rst      = 1'b0;
        sw_rst     = '0;
        designs_cs = cs;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        n_rst      = 1'b0;
        designs_cs = '1;
        sw_rst     = '0;
        #2;
        n_checks++;
        if (designs_rst !== 4'b1111 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: rst=%b done=%b, expected rst=1111 done=0", designs_rst, seq_done);
        end else begin
            $display("reset_async: rst=%b done=%b ok", designs_rst, seq_done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (designs_rst !== 4'b1111 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: rst=%b done=%b, expected rst=1111 done=0", designs_rst, seq_done);
        end else begin
            $display("reset_held: rst=%b done=%b ok", designs_rst, seq_done);
        end
    endtask

    task automatic test_power_on();
        exp_t e;
        start_seq('1);
        for (int c = 1; c <= 26; c++) begin
            exp_q.push_back('{cyc: c, rst: po_rst(c), done: (c >= 22)});
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (designs_rst !== e.rst || seq_done !== e.done || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL power_on edge %0d: rst=%b done=%b, expected rst=%b done=%b", cyc, designs_rst, seq_done, e.rst, e.done);
            end else begin
                $display("power_on edge %0d: rst=%b done=%b ok", cyc, designs_rst, seq_done);
            end
        end
    endtask

    // Runs directly after test_power_on: both checks land between clock edges.
    task automatic test_async_assert();
        #3;
        designs_cs[2] = 1'b0;
        #1;
        n_checks++;
        if (designs_rst !== 4'b0010 || seq_done !== 1'b1) begin
            n_fail++;
            $display("FAIL async_cs_drop: rst=%b done=%b, expected rst=0010 done=1", designs_rst, seq_done);
        end else begin
            $display("async_cs_drop: rst=%b done=%b ok", designs_rst, seq_done);
        end
        #1;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (designs_rst !== 4'b1111 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_nrst: rst=%b done=%b, expected rst=1111 done=0", designs_rst, seq_done);
        end else begin
            $display("async_nrst: rst=%b done=%b ok", designs_rst, seq_done);
        end
        designs_cs = '1;
    endtask

    task automatic test_reselect();
        exp_t        e;
        logic [NP:1] r;
        start_seq(4'b1011);
        for (int c = 1; c <= 44; c++) begin
            r = po_rst(c);
            if (c < 40) r[3] = 1'b1;
            exp_q.push_back('{cyc: c, rst: r, done: (c >= 22)});
        end
        while (exp_q.size() > 0) begin
            if (cyc == 30) designs_cs[3] = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (designs_rst !== e.rst || seq_done !== e.done || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL reselect edge %0d: rst=%b done=%b, expected rst=%b done=%b", cyc, designs_rst, seq_done, e.rst, e.done);
            end else begin
                $display("reselect edge %0d: rst=%b done=%b ok", cyc, designs_rst, seq_done);
            end
        end
    endtask

    task automatic test_sw_rst();
        exp_t        e;
        logic [NP:1] r;
        start_seq('1);
        for (int c = 1; c <= 100; c++) begin
            r = po_rst(c);
            if (c >= 50 && c < 58) r[2] = 1'b1;
            if (c >= 70 && c < 82) r[2] = 1'b1;
            if (c >= 90 && c < 98) begin
                r[1] = 1'b1;
                r[4] = 1'b1;
            end
            exp_q.push_back('{cyc: c, rst: r, done: (c >= 22)});
        end
        while (exp_q.size() > 0) begin
            sw_rst = '0;
            if (cyc + 1 == 50 || cyc + 1 == 70 || cyc + 1 == 74) sw_rst[2] = 1'b1;
            if (cyc + 1 == 90) begin
                sw_rst[1] = 1'b1;
                sw_rst[4] = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (designs_rst !== e.rst || seq_done !== e.done || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL sw_rst edge %0d: rst=%b done=%b, expected rst=%b done=%b", cyc, designs_rst, seq_done, e.rst, e.done);
            end else begin
                $display("sw_rst edge %0d: rst=%b done=%b ok", cyc, designs_rst, seq_done);
            end
        end
        sw_rst = '0;
    endtask

    task automatic test_cs_drop();
        exp_t        e;
        logic [NP:1] r;
        start_seq('1);
        for (int c = 1; c <= 60; c++) begin
            r = po_rst(c);
            if (c >= 30 && c < 55) r[1] = 1'b1;
            exp_q.push_back('{cyc: c, rst: r, done: (c >= 22)});
        end
        while (exp_q.size() > 0) begin
            sw_rst = '0;
            if (cyc + 1 == 30) sw_rst[1] = 1'b1;
            if (cyc == 33) designs_cs[1] = 1'b0;
            if (cyc == 45) designs_cs[1] = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (designs_rst !== e.rst || seq_done !== e.done || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL cs_drop edge %0d: rst=%b done=%b, expected rst=%b done=%b", cyc, designs_rst, seq_done, e.rst, e.done);
            end else begin
                $display("cs_drop edge %0d: rst=%b done=%b ok", cyc, designs_rst, seq_done);
            end
        end
        sw_rst = '0;
    endtask

    task automatic test_abort();
        exp_t e;
        start_seq('1);
        for (int c = 1; c <= 16; c++) begin
            exp_q.push_back('{cyc: c, rst: po_rst(c), done: 1'b0});
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (designs_rst !== e.rst || seq_done !== e.done || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL abort_pre edge %0d: rst=%b done=%b, expected rst=%b done=%b", cyc, designs_rst, seq_done, e.rst, e.done);
            end else begin
                $display("abort_pre edge %0d: rst=%b done=%b ok", cyc, designs_rst, seq_done);
            end
        end
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (designs_rst !== 4'b1111 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_assert: rst=%b done=%b, expected rst=1111 done=0", designs_rst, seq_done);
        end else begin
            $display("abort_assert: rst=%b done=%b ok", designs_rst, seq_done);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc   = 0;
        for (int c = 1; c <= 26; c++) begin
            exp_q.push_back('{cyc: c, rst: po_rst(c), done: (c >= 22)});
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            n_checks++;
            if (designs_rst !== e.rst || seq_done !== e.done || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL abort_restart edge %0d: rst=%b done=%b, expected rst=%b done=%b", cyc, designs_rst, seq_done, e.rst, e.done);
            end else begin
                $display("abort_restart edge %0d: rst=%b done=%b ok", cyc, designs_rst, seq_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_async_assert();
        test_reselect();
        test_sw_rst();
        test_cs_drop();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reset_sequencer
